alu_mc: RTL

Multi-cycle, parametrised-width integer ALU with valid/ready handshakes on both sides, for use in pipelined datapaths. Single-cycle operations register their result with one-cycle latency. Divide and remainder run on an iterative radix-2 divider. One operation is in flight at a time. The result and flags are held until the consumer accepts them.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_mc_if.sv | 39 +++
 rtl/alu_div.sv | 71 +++++++
 rtl/alu_mc.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU (alu_mc):
//   - func_t    : 4-bit opcode type
//   - OP_*      : opcode constants (14 and 15 are unsupported)
//   - state_t   : controller state encoding. DIV_BUSY exists only when the
//                 ALU_MC_DIV_EN macro is defined.
//   - is_div_op : true for the opcodes handled by the iterative divider
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef logic [3:0] func_t;

   localparam func_t OP_ADD  = 4'd0;
   localparam func_t OP_SUB  = 4'd1;
   localparam func_t OP_MUL  = 4'd2;
   localparam func_t OP_DIV  = 4'd3;
   localparam func_t OP_AND  = 4'd4;
   localparam func_t OP_OR   = 4'd5;
   localparam func_t OP_XOR  = 4'd6;
   localparam func_t OP_NOT  = 4'd7;
   localparam func_t OP_SHL  = 4'd8;
   localparam func_t OP_SHR  = 4'd9;
   localparam func_t OP_SLT  = 4'd10;
   localparam func_t OP_SLTU = 4'd11;
   localparam func_t OP_SRA  = 4'd12;
   localparam func_t OP_REM  = 4'd13;

`ifdef ALU_MC_DIV_EN
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DIV_BUSY = 2'd1,
      ST_DONE     = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DONE = 2'd2
   } state_t;
`endif

   function automatic logic is_div_op(input func_t f);
      return (f == OP_DIV) || (f == OP_REM);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
// Request/response bundle of the multi-cycle ALU.
// Handshake: a request transfers on a cycle with in_valid && in_ready; a
// result transfers on a cycle with out_valid && out_ready. The producer of
// *_valid keeps its payload stable until the transfer happens.
//   master : request producer / result consumer
//   slave  : the ALU
// Signals: in_valid, in_ready, func, a, b, out_valid, out_ready, res,
//          is_zero, illegal, busy.
// -----------------------------------------------------------------------------
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   func_t            func;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             is_zero;
   logic             illegal;
   logic             busy;

   modport master (
      output in_valid, func, a, b, out_ready,
      input  in_ready, out_valid, res, is_zero, illegal, busy
   );

   modport slave (
      input  in_valid, func, a, b, out_ready,
      output in_ready, out_valid, res, is_zero, illegal, busy
   );

endinterface

// File: rtl/alu_div.sv
// -----------------------------------------------------------------------------
// alu_div
// Iterative unsigned radix-2 restoring divider, one quotient bit per cycle.
// Only built when ALU_MC_DIV_EN is defined.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   i_start               : load operands and begin WIDTH iterations
//   i_dividend, i_divisor : operands, sampled on i_start
//   o_done                : the current cycle performs the final iteration;
//                           o_quot/o_rem then carry the final answer
//   o_quot, o_rem         : quotient/remainder after the current iteration
// A zero divisor needs no special case: every trial subtraction succeeds,
// giving an all-ones quotient and a remainder equal to the dividend.
// -----------------------------------------------------------------------------
module alu_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem
);

   localparam int CW = $clog2(WIDTH) + 1;

   // r_quot starts as the dividend; its MSBs shift into the partial
   // remainder while quotient bits shift in at the bottom.
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_divisor;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_fits;

   always_comb begin
      w_shift = {r_rem, r_quot[WIDTH-1]};
      w_trial = w_shift - {1'b0, r_divisor};
      // Partial remainder stays below the divisor, so the top bit of the
      // trial difference is a pure borrow flag.
      w_fits  = ~w_trial[WIDTH];
      o_quot  = {r_quot[WIDTH-2:0], w_fits};
      o_rem   = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
   end

   assign o_done = (r_cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_quot    <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
         r_cnt     <= '0;
      end else if (i_start) begin
         r_quot    <= i_dividend;
         r_rem     <= '0;
         r_divisor <= i_divisor;
         r_cnt     <= CW'(WIDTH);
      end else if (r_cnt != '0) begin
         r_quot    <= o_quot;
         r_rem     <= o_rem;
         r_cnt     <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle integer ALU with valid/ready on both sides. Single-cycle ops
// register their result one cycle after acceptance; DIV/REM use the
// iterative divider (alu_div) and complete WIDTH cycles after acceptance.
// One operation in flight; the result is held until out_ready.
// Configuration macro: ALU_MC_DIV_EN
//   defined   : divider present, DIV/REM are unsigned divide/remainder
//   undefined : no divider, DIV/REM finish in one cycle as illegal, busy = 0
// Ports:
//   clk, rst_n : clock, async active-low reset
//   s_if       : alu_mc_if slave modport (request/response handshakes)
//   o_state    : controller state, for observation
// in_ready depends combinationally on out_ready only; all other outputs are
// registered.
// -----------------------------------------------------------------------------
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_mc_if.slave  s_if,
   output state_t   o_state
);

   state_t           r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_res;
   logic             r_is_zero;
   logic             r_illegal;

   logic [WIDTH-1:0] w_res;
   logic             w_illegal;
   logic [SHW-1:0]   w_shamt;
   logic             w_accept;

   // ---------------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------------
   always_comb begin
      w_res     = '0;
      w_illegal = 1'b0;
      w_shamt   = s_if.b[SHW-1:0];
      case (s_if.func)
         OP_ADD:  w_res = s_if.a + s_if.b;
         OP_SUB:  w_res = s_if.a - s_if.b;
         OP_MUL:  w_res = s_if.a * s_if.b;
         OP_AND:  w_res = s_if.a & s_if.b;
         OP_OR:   w_res = s_if.a | s_if.b;
         OP_XOR:  w_res = s_if.a ^ s_if.b;
         OP_NOT:  w_res = ~s_if.a;
         OP_SHL:  w_res = s_if.a << w_shamt;
         OP_SHR:  w_res = s_if.a >> w_shamt;
         OP_SRA:  w_res = $signed(s_if.a) >>> w_shamt;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(s_if.a) < $signed(s_if.b))};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (s_if.a < s_if.b)};
`ifdef ALU_MC_DIV_EN
         OP_DIV, OP_REM: w_res = '0;   // result comes from the divider
`endif
         default: w_illegal = 1'b1;
      endcase
   end

   assign s_if.in_ready = (r_state == ST_IDLE) ||
                          ((r_state == ST_DONE) && s_if.out_ready);
   assign w_accept      = s_if.in_valid && s_if.in_ready;

`ifdef ALU_MC_DIV_EN
   // ---------------------------------------------------------------------
   // Divider
   // ---------------------------------------------------------------------
   logic             r_busy;
   logic             r_is_rem;
   logic             w_div_op;
   logic             w_div_done;
   logic [WIDTH-1:0] w_div_quot;
   logic [WIDTH-1:0] w_div_rem;
   logic [WIDTH-1:0] w_div_res;

   assign w_div_op  = is_div_op(s_if.func);
   assign w_div_res = r_is_rem ? w_div_rem : w_div_quot;

   alu_div #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_accept && w_div_op),
      .i_dividend (s_if.a),
      .i_divisor  (s_if.b),
      .o_done     (w_div_done),
      .o_quot     (w_div_quot),
      .o_rem      (w_div_rem)
   );

   assign s_if.busy = r_busy;
`else
   assign s_if.busy = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Controller
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_res       <= '0;
         r_is_zero   <= 1'b1;
         r_illegal   <= 1'b0;
`ifdef ALU_MC_DIV_EN
         r_busy      <= 1'b0;
         r_is_rem    <= 1'b0;
`endif
      end else begin
         case (r_state)
            // IDLE and DONE share the accept path; in DONE an accept
            // implies out_ready, so the old result drains on the same edge.
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
`ifdef ALU_MC_DIV_EN
                  if (w_div_op) begin
                     r_state     <= ST_DIV_BUSY;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b1;
                     r_is_rem    <= (s_if.func == OP_REM);
                  end else
`endif
                  begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                     r_res       <= w_res;
                     r_is_zero   <= (w_res == '0);
                     r_illegal   <= w_illegal;
                  end
               end else if ((r_state == ST_DONE) && s_if.out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
`ifdef ALU_MC_DIV_EN
            ST_DIV_BUSY: begin
               if (w_div_done) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_res       <= w_div_res;
                  r_is_zero   <= (w_div_res == '0);
                  r_illegal   <= 1'b0;
               end
            end
`endif
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign s_if.out_valid = r_out_valid;
   assign s_if.res       = r_res;
   assign s_if.is_zero   = r_is_zero;
   assign s_if.illegal   = r_illegal;
   assign o_state        = r_state;

endmodule
